// File: rtl/store_drain_queue.sv
// Store drain queue: posts committed stores into a small circular FIFO and
// drains them to a shared single-port data memory. Loads get priority on the
// memory port, limited by an anti-starvation counter. Loads are forwarded
// from queued stores (and from a same-cycle incoming store) so they never
// observe stale memory contents.
module store_drain_queue #(
    parameter int WORD_SIZE_P = 16,
    parameter int DQ_ENTRY    = 4,
    parameter int STARVE_MAX  = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   sb_mem_v_i,
    input  logic [WORD_SIZE_P-1:0] sb_mem_addr_i,
    input  logic [WORD_SIZE_P-1:0] sb_mem_data_i,
    output logic                   dq_full_o,
    output logic                   dq_overflow_o,
    input  logic                   rob_mispredict_i,
    input  logic                   ld_v_i,
    input  logic [WORD_SIZE_P-1:0] ld_addr_i,
    output logic                   ld_ready_o,
    output logic                   ld_v_o,
    output logic [WORD_SIZE_P-1:0] ld_data_o,
    output logic                   mem_v_o,
    output logic                   mem_w_o,
    output logic [WORD_SIZE_P-1:0] mem_addr_o,
    output logic [WORD_SIZE_P-1:0] mem_wdata_o,
    input  logic [WORD_SIZE_P-1:0] mem_rdata_i
);

    localparam int PTR_W = $clog2(DQ_ENTRY);
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    // Queue storage: no reset needed, validity is tracked by head/count.
    logic [WORD_SIZE_P-1:0] dq_addr_q [DQ_ENTRY];
    logic [WORD_SIZE_P-1:0] dq_data_q [DQ_ENTRY];

    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [ST_W-1:0]        starve_cnt_q, starve_cnt_d;
    logic                   resp_v_q, resp_v_d;
    logic                   fwd_hit_q, fwd_hit_d;
    logic [WORD_SIZE_P-1:0] fwd_data_q, fwd_data_d;
    logic                   overflow_q, overflow_d;

    logic                   not_empty;
    logic                   full;
    logic                   force_drain;
    logic                   ld_go;
    logic                   drain;
    logic                   push;
    logic [DQ_ENTRY-1:0]    slot_match;
    logic [PTR_W-1:0]       fwd_idx;

    // Per-slot match: slot is live when its distance from head is below count.
    for (genvar gi = 0; gi < DQ_ENTRY; gi++) begin : g_slot
        logic [PTR_W-1:0] offset;
        assign offset         = PTR_W'(gi) - head_q;
        assign slot_match[gi] = ({1'b0, offset} < count_q) && (dq_addr_q[gi] == ld_addr_i);
    end

    // Arbitration between loads and drains, plus push acceptance.
    always_comb begin
        not_empty   = (count_q != '0);
        full        = (count_q == CNT_W'(DQ_ENTRY));
        force_drain = not_empty && (starve_cnt_q == ST_W'(STARVE_MAX));
        // A mispredict in the same cycle blocks new loads as well.
        ld_ready_o  = ~force_drain & ~rob_mispredict_i;
        ld_go       = ld_v_i & ld_ready_o;
        drain       = not_empty & ~ld_go;
        // A drain in the same cycle frees a slot even when full.
        push        = sb_mem_v_i & (~full | drain);
    end

    // Youngest-match forwarding: walk oldest to youngest so later hits win,
    // then let the same-cycle incoming store override everything.
    always_comb begin
        fwd_hit_d  = 1'b0;
        fwd_data_d = '0;
        fwd_idx    = head_q;
        for (int k = 0; k < DQ_ENTRY; k++) begin
            fwd_idx = head_q + PTR_W'(k);
            if (slot_match[fwd_idx]) begin
                fwd_hit_d  = 1'b1;
                fwd_data_d = dq_data_q[fwd_idx];
            end
        end
        if (push && (sb_mem_addr_i == ld_addr_i)) begin
            fwd_hit_d  = 1'b1;
            fwd_data_d = sb_mem_data_i;
        end
    end

    // Next-state for pointers, occupancy, starvation and error flag.
    always_comb begin
        head_d     = drain ? head_q + PTR_W'(1) : head_q;
        tail_d     = push  ? tail_q + PTR_W'(1) : tail_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(drain);
        resp_v_d   = ld_go;
        overflow_d = overflow_q | (sb_mem_v_i & full & ~drain);
        if (!not_empty || drain) begin
            starve_cnt_d = '0;
        end else if (ld_go && (starve_cnt_q != ST_W'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + ST_W'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Control and response registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            starve_cnt_q <= '0;
            resp_v_q     <= 1'b0;
            fwd_hit_q    <= 1'b0;
            fwd_data_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            starve_cnt_q <= starve_cnt_d;
            resp_v_q     <= resp_v_d;
            fwd_hit_q    <= fwd_hit_d;
            fwd_data_q   <= fwd_data_d;
            overflow_q   <= overflow_d;
        end
    end

    // Queue entry write at tail.
    always_ff @(posedge clk_i) begin
        if (push) begin
            dq_addr_q[tail_q] <= sb_mem_addr_i;
            dq_data_q[tail_q] <= sb_mem_data_i;
        end
    end

    // Output drive: memory port, load response and status.
    always_comb begin
        mem_v_o       = ld_go | drain;
        mem_w_o       = drain;
        mem_addr_o    = ld_go ? ld_addr_i : dq_addr_q[head_q];
        mem_wdata_o   = dq_data_q[head_q];
        ld_v_o        = resp_v_q & ~rob_mispredict_i;
        ld_data_o     = fwd_hit_q ? fwd_data_q : mem_rdata_i;
        dq_full_o     = full;
        dq_overflow_o = overflow_q;
    end

endmodule

// File: tb/tb_store_drain_queue.sv
// Testbench for store_drain_queue: cycle-level reference model of occupancy,
// starvation and overflow, a write-order scoreboard and a load-data
// scoreboard fed from architectural store order.
module tb_store_drain_queue;

    localparam int W      = 16;
    localparam int DEPTH  = 4;
    localparam int STARVE = 8;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          sb_mem_v_i;
    logic [W-1:0]  sb_mem_addr_i;
    logic [W-1:0]  sb_mem_data_i;
    logic          dq_full_o;
    logic          dq_overflow_o;
    logic          rob_mispredict_i;
    logic          ld_v_i;
    logic [W-1:0]  ld_addr_i;
    logic          ld_ready_o;
    logic          ld_v_o;
    logic [W-1:0]  ld_data_o;
    logic          mem_v_o;
    logic          mem_w_o;
    logic [W-1:0]  mem_addr_o;
    logic [W-1:0]  mem_wdata_o;
    logic [W-1:0]  mem_rdata_i;

    store_drain_queue #(
        .WORD_SIZE_P(W),
        .DQ_ENTRY   (DEPTH),
        .STARVE_MAX (STARVE)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .sb_mem_v_i      (sb_mem_v_i),
        .sb_mem_addr_i   (sb_mem_addr_i),
        .sb_mem_data_i   (sb_mem_data_i),
        .dq_full_o       (dq_full_o),
        .dq_overflow_o   (dq_overflow_o),
        .rob_mispredict_i(rob_mispredict_i),
        .ld_v_i          (ld_v_i),
        .ld_addr_i       (ld_addr_i),
        .ld_ready_o      (ld_ready_o),
        .ld_v_o          (ld_v_o),
        .ld_data_o       (ld_data_o),
        .mem_v_o         (mem_v_o),
        .mem_w_o         (mem_w_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_rdata_i     (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous single-port memory; unwritten words hold a known pattern.
    logic [W-1:0] mem_arr [int];

    function automatic logic [W-1:0] init_word(input int a);
        return 16'hA000 ^ 16'(a);
    endfunction

    always @(posedge clk_i) begin
        if (mem_v_o) begin
            if (mem_w_o) begin
                mem_arr[int'(mem_addr_o)] = mem_wdata_o;
            end else if (mem_arr.exists(int'(mem_addr_o))) begin
                mem_rdata_i <= mem_arr[int'(mem_addr_o)];
            end else begin
                mem_rdata_i <= init_word(int'(mem_addr_o));
            end
        end
    end

    // Architectural value of each address in store commit order.
    logic [W-1:0] ref_val [int];

    function automatic logic [W-1:0] ref_read(input logic [W-1:0] a);
        if (ref_val.exists(int'(a))) return ref_val[int'(a)];
        return init_word(int'(a));
    endfunction

    int           checks_n   = 0;
    int           failures_n = 0;
    int           cnt_m      = 0;
    int           st_m       = 0;
    bit           ovf_m      = 1'b0;
    bit           resp_m     = 1'b0;
    logic [31:0]  wq [$];
    logic [W-1:0] lq [$];
    logic         last_rdy;
    int           first_low;
    int           sent;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_n++;
        if (obs !== exp) begin
            failures_n++;
            $display("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_i          = 1'b1;
        sb_mem_v_i       = 1'b0;
        sb_mem_addr_i    = '0;
        sb_mem_data_i    = '0;
        rob_mispredict_i = 1'b0;
        ld_v_i           = 1'b0;
        ld_addr_i        = '0;
        @(negedge clk_i);
        check_eq("rst_ld_ready", 32'(ld_ready_o), 32'd1);
        check_eq("rst_dq_full", 32'(dq_full_o), 32'd0);
        check_eq("rst_mem_v", 32'(mem_v_o), 32'd0);
        check_eq("rst_mem_w", 32'(mem_w_o), 32'd0);
        check_eq("rst_ld_v", 32'(ld_v_o), 32'd0);
        check_eq("rst_overflow", 32'(dq_overflow_o), 32'd0);
        $display("reset applied");
        cnt_m  = 0;
        st_m   = 0;
        ovf_m  = 1'b0;
        resp_m = 1'b0;
        wq.delete();
        lq.delete();
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    // One clock cycle: drive, check against the model mid-cycle, advance model.
    task automatic cyc(input logic sv, input logic [W-1:0] sa, input logic [W-1:0] sd,
                       input logic lv, input logic [W-1:0] la, input logic mp);
        bit           force_m, rdy_m, go_m, drain_m, push_m, lv_exp;
        logic [31:0]  w;
        logic [W-1:0] ld_exp;
        sb_mem_v_i       = sv;
        sb_mem_addr_i    = sa;
        sb_mem_data_i    = sd;
        ld_v_i           = lv;
        ld_addr_i        = la;
        rob_mispredict_i = mp;
        force_m = (cnt_m != 0) && (st_m == STARVE);
        rdy_m   = !force_m && !mp;
        go_m    = lv && rdy_m;
        drain_m = (cnt_m != 0) && !go_m;
        push_m  = sv && ((cnt_m < DEPTH) || drain_m);
        @(negedge clk_i);
        last_rdy = ld_ready_o;
        check_eq("ld_ready", 32'(ld_ready_o), 32'(rdy_m));
        check_eq("dq_full", 32'(dq_full_o), 32'(cnt_m == DEPTH));
        check_eq("overflow", 32'(dq_overflow_o), 32'(ovf_m));
        check_eq("mem_v", 32'(mem_v_o), 32'(go_m || drain_m));
        if (go_m) begin
            check_eq("mem_w_load", 32'(mem_w_o), 32'd0);
            check_eq("mem_raddr", 32'(mem_addr_o), 32'(la));
        end
        if (drain_m) begin
            check_eq("mem_w_drain", 32'(mem_w_o), 32'd1);
            if (wq.size() > 0) begin
                w = wq.pop_front();
                check_eq("wr_addr", 32'(mem_addr_o), 32'(w[31:16]));
                check_eq("wr_data", 32'(mem_wdata_o), 32'(w[15:0]));
                $display("write addr=%h data=%h", mem_addr_o, mem_wdata_o);
            end
        end
        lv_exp = resp_m && !mp;
        check_eq("ld_v", 32'(ld_v_o), 32'(lv_exp));
        if (resp_m && lq.size() > 0) begin
            ld_exp = lq.pop_front();
            if (lv_exp) begin
                check_eq("ld_data", 32'(ld_data_o), 32'(ld_exp));
                $display("load resp data=%h expected=%h", ld_data_o, ld_exp);
            end else begin
                $display("load response flushed");
            end
        end
        if (sv && (cnt_m == DEPTH) && !drain_m) ovf_m = 1'b1;
        if (push_m) begin
            ref_val[int'(sa)] = sd;
            wq.push_back({sa, sd});
        end
        if (go_m) lq.push_back(ref_read(la));
        resp_m = go_m;
        if ((cnt_m == 0) || drain_m) st_m = 0;
        else if (go_m && (st_m < STARVE)) st_m++;
        cnt_m = cnt_m + int'(push_m) - int'(drain_m);
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic drain_all();
        for (int i = 0; i < 12; i++) begin
            if (cnt_m != 0) idle();
        end
        idle();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // Single store drains the next cycle; then read it back through memory.
        cyc(1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0, 1'b0);
        idle();
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h0010, 1'b0);
        idle();

        // Fill while loading, then overflow with a load in the same cycle.
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 16'h0080 + 16'(i), 16'h8000 + 16'(i), 1'b1, 16'h0090, 1'b0);
        cyc(1'b1, 16'h0084, 16'h8004, 1'b1, 16'h0090, 1'b0);
        check_eq("overflow_set", 32'(dq_overflow_o), 32'd1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h0084, 1'b0);
        drain_all();
        check_eq("overflow_sticky", 32'(dq_overflow_o), 32'd1);
        do_reset();

        // Fill again; push exactly in the forced-drain cycle: no overflow.
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 16'h0080 + 16'(i), 16'h8100 + 16'(i), 1'b1, 16'h0090, 1'b0);
        for (int i = 0; i < 12; i++) begin
            bit f;
            f = (cnt_m != 0) && (st_m == STARVE);
            cyc(f, 16'h0088, 16'h8888, 1'b1, 16'h0088, 1'b0);
            if (f) begin
                check_eq("forced_push_full", 32'(dq_full_o), 32'd1);
                check_eq("forced_push_no_ovf", 32'(dq_overflow_o), 32'd0);
                break;
            end
        end
        drain_all();

        // Forwarding: youngest queued store wins, then same-cycle store wins.
        cyc(1'b1, 16'h0020, 16'h1111, 1'b1, 16'h0091, 1'b0);
        cyc(1'b1, 16'h0020, 16'h2222, 1'b1, 16'h0092, 1'b0);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h0020, 1'b0);
        cyc(1'b1, 16'h0020, 16'h3333, 1'b1, 16'h0020, 1'b0);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h0020, 1'b0);
        drain_all();

        // Starvation: queue non-empty from cycle 2, forced drain on cycle 10.
        first_low = 0;
        cyc(1'b1, 16'h0070, 16'h7777, 1'b1, 16'h0071, 1'b0);
        for (int c = 2; c <= 12; c++) begin
            cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h0071, 1'b0);
            if (!last_rdy && (first_low == 0)) first_low = c;
        end
        check_eq("starve_cycle", 32'(first_low), 32'd10);
        drain_all();

        // Flush: accepted load killed next cycle; stores still drain in order.
        cyc(1'b1, 16'h0050, 16'hAAAA, 1'b1, 16'h0040, 1'b0);
        cyc(1'b1, 16'h0051, 16'hBBBB, 1'b1, 16'h0040, 1'b1);
        drain_all();

        // Wrap-around: 10 stores at uneven rates with interleaved loads.
        sent = 0;
        for (int i = 0; (i < 60) && (sent < 10); i++) begin
            bit s;
            s = ((i % 3) != 2) && (cnt_m < DEPTH);
            cyc(s, 16'h0060 + 16'(i % 4), 16'h5000 + 16'(i), ((i % 2) == 0),
                16'h0060 + 16'((i + 1) % 4), 1'b0);
            if (s) sent++;
        end
        drain_all();
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h0063, 1'b0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, failures_n);
        $finish;
    end

endmodule

// File: doc/store_drain_queue.md
Name: store_drain_queue

Overview:
- Memory-side responder for the store buffer's commit port (sb_mem_v/addr/data), which has no backpressure.
- Posts every committed store into a small FIFO.
- Drains the FIFO to the single-port synchronous data memory, which it shares with execute-stage loads.
- Loads get priority, bounded by an anti-starvation counter. Loads are forwarded from pending queued stores so they never read stale memory.

Parameters:
WORD_SIZE_P, 16, data/address width in bits
DQ_ENTRY, 4, drain queue depth (power of 2, >=2)
STARVE_MAX, 8, consecutive load-blocked drain cycles before one drain slot is forced

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  asynchronous active-high reset
sb_mem_v_i  in  1  committed store valid; no backpressure
sb_mem_addr_i  in  WORD_SIZE_P  store address
sb_mem_data_i  in  WORD_SIZE_P  store data
dq_full_o  out  1  queue holds DQ_ENTRY entries; ROB must not commit a store this cycle
dq_overflow_o  out  1  sticky error: a store arrived while full with no pop
rob_mispredict_i  in  1  flush; kills only the in-flight load response
ld_v_i  in  1  load request valid
ld_addr_i  in  WORD_SIZE_P  load address
ld_ready_o  out  1  load accepted this cycle when ld_v_i & ld_ready_o
ld_v_o  out  1  load response valid
ld_data_o  out  WORD_SIZE_P  load response data
mem_v_o  out  1  memory access this cycle
mem_w_o  out  1  1 = write, 0 = read
mem_addr_o  out  WORD_SIZE_P  memory address
mem_wdata_o  out  WORD_SIZE_P  memory write data
mem_rdata_i  in  WORD_SIZE_P  read data, valid the cycle after a read

Behaviour:
- State:
  - Circular FIFO of {addr, data}.
  - Head/tail pointers, $clog2(DQ_ENTRY) bits, wrapping modulo DQ_ENTRY.
  - Count register, $clog2(DQ_ENTRY)+1 bits.
  - Starvation counter starve_cnt.
  - Response registers: resp_v, fwd_hit, fwd_data.
- Reset (async, reset_i high): pointers, count, starve_cnt, resp_v and dq_overflow_o go to 0.
  - Outputs then read: dq_full_o=0, ld_v_o=0, mem_v_o=0, mem_w_o=0, ld_ready_o=1.
  - Queue contents are discarded; reset mid-drain loses pending stores by definition.
- Arbitration (combinational, each cycle):
  - force_drain = (count!=0) & (starve_cnt==STARVE_MAX).
  - ld_ready_o = ~force_drain.
  - ld_go = ld_v_i & ld_ready_o.
  - drain = (count!=0) & ~ld_go.
- Memory drive:
  - ld_go: mem_v_o=1, mem_w_o=0, mem_addr_o=ld_addr_i.
  - drain: mem_v_o=1, mem_w_o=1, addr/wdata taken from the head entry.
  - Otherwise mem_v_o=0.
- Starvation counter:
  - starve_cnt++ when count!=0 & ld_go.
  - Cleared on drain or when count==0.
  - Saturates at STARVE_MAX.
- Push:
  - sb_mem_v_i is accepted when count<DQ_ENTRY or drain is true this cycle; the entry is written at tail and tail++.
  - sb_mem_v_i while count==DQ_ENTRY and no drain: store dropped, dq_overflow_o set until reset.
- Pop: on drain, head++.
- Count update: count_n = count + push - pop. Simultaneous push and pop at full leaves count at DQ_ENTRY.
- dq_full_o = (count==DQ_ENTRY), combinational from the register.
- Forwarding, evaluated in the ld_go cycle:
  - Compare ld_addr_i against all valid queue entries, plus the same-cycle incoming store.
  - The youngest match wins, in order: incoming store, then the entry nearest tail, searched tail-1 back to head with wrap.
  - The head entry being drained is never concurrent with ld_go, so there is no conflict.
- Load latency: 1 cycle.
  - Cycle T ld_go; cycle T+1 ld_v_o=1.
  - ld_data_o = fwd_data if fwd_hit, else mem_rdata_i.
- Flush:
  - rob_mispredict_i at T+1 forces ld_v_o=0.
  - rob_mispredict_i at T forces ld_ready_o=0, so no new load is accepted.
  - The queue is never flushed; its entries are committed.
- Back-to-back loads are fully pipelined, one per cycle.

Test Plan:
- Reset → ld_ready_o=1, dq_full_o=0, mem_v_o=0, ld_v_o=0. Push store A=0x0010 D=0xBEEF with no loads → next cycle mem_w write 0x0010/0xBEEF; count returns to 0.
- Push 4 stores while continuously loading → dq_full_o=1. A 5th store with a load still in the same cycle → dq_overflow_o=1 and sticky. Repeat with the forced-drain cycle coinciding with the push → no overflow, count stays 4.
- Stores to 0x0020 with data 0x1111 then 0x2222 queued, then load 0x0020 → ld_v_o next cycle, ld_data_o=0x2222 (youngest), no memory read used for data. Load with same-cycle incoming store 0x0020=0x3333 → 0x3333.
- Queue non-empty with ld_v_i held high for 9+ cycles, STARVE_MAX=8 → ld_ready_o=0 on exactly the 9th cycle, one write drains, starve_cnt cleared.
- Load to 0x0040 accepted, rob_mispredict_i high the next cycle → ld_v_o=0; queued stores still drain in order.
- Wrap-around: push/pop 10 stores at alternating rates → memory writes occur in exact push order, forwarding stays correct across the pointer wrap.
